// File: rtl/dds_phase_accum_seq.sv
// Phase-accumulator front end for the DDS: sample indexing, offset-corrected phase to the sine LUT.
// Optional macro DDS_PHASE_DITHER_EN adds LFSR dither ahead of the phase truncation.
module dds_phase_accum_seq #(
    parameter int                     PH_ACC_BITS      = 24,
    parameter logic [PH_ACC_BITS-1:0] PH_INC           = 24'h010000,
    parameter int                     FREQ_OFFSET_BITS = 10,
    parameter int                     PH_OFFSET_BITS   = 10,
    parameter int                     OUT_BITS         = 10,
    parameter int                     RUN_LENGTH       = 510
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        INIT,
    input  logic                        ENABLE,
    input  logic [FREQ_OFFSET_BITS-1:0] FREQ_OFFSET,
    input  logic                        FREQ_OFFSET_WE,
    input  logic [PH_OFFSET_BITS-1:0]   PH_OFFSET,
    input  logic                        PH_OFFSET_WE,
    output logic [9:0]                  SAMPLE_NUM,
    output logic [OUT_BITS-1:0]         PHASE_OUT,
    output logic                        OUT_VALID,
    output logic                        DONE
);

    localparam int         SEXT_BITS = PH_ACC_BITS - FREQ_OFFSET_BITS;
    localparam int         PAD_BITS  = OUT_BITS - PH_OFFSET_BITS;
    localparam int         DROP_BITS = PH_ACC_BITS - OUT_BITS;
    localparam logic [9:0] LAST_IDX  = 10'(RUN_LENGTH - 1);

    // OUT_VALID is a one-cycle qualifier with no backpressure: PHASE_OUT carries a
    // new sample exactly in the cycles OUT_VALID is high, and holds otherwise.

    logic [PH_ACC_BITS-1:0]    inc_reg;
    logic [PH_OFFSET_BITS-1:0] phoff_reg;
    logic [PH_ACC_BITS-1:0]    acc;
    logic                      v1;

    logic                      active;
    logic [PH_ACC_BITS-1:0]    inc_load;
    logic [PH_ACC_BITS-1:0]    acc_round;
    logic [OUT_BITS-1:0]       acc_top;
    logic [OUT_BITS-1:0]       phoff_aligned;
    logic [OUT_BITS-1:0]       phase_next;

`ifdef DDS_PHASE_DITHER_EN
    localparam logic [PH_ACC_BITS-1:0] DITH_MASK =
        (PH_ACC_BITS'(1) << DROP_BITS) - PH_ACC_BITS'(1);

    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign acc_round = acc + (PH_ACC_BITS'(lfsr) & DITH_MASK);

    always_ff @(posedge CLK) begin
        if (!RSTN || INIT) begin
            lfsr <= 16'hACE1;
        end else if (active) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign acc_round = acc;
`endif

    always_comb begin
        active        = ENABLE & ~DONE & ~INIT;
        inc_load      = PH_INC + {{SEXT_BITS{FREQ_OFFSET[FREQ_OFFSET_BITS-1]}}, FREQ_OFFSET};
        acc_top       = OUT_BITS'(acc_round >> DROP_BITS);
        phoff_aligned = OUT_BITS'(phoff_reg) << PAD_BITS;
        phase_next    = acc_top + phoff_aligned;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            inc_reg    <= PH_INC;
            phoff_reg  <= '0;
            acc        <= '0;
            v1         <= 1'b0;
            SAMPLE_NUM <= '0;
            PHASE_OUT  <= '0;
            OUT_VALID  <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            // Offset loads bypass ENABLE/DONE/INIT; the new value is seen next cycle.
            if (FREQ_OFFSET_WE) inc_reg <= inc_load;
            if (PH_OFFSET_WE)   phoff_reg <= PH_OFFSET;

            if (INIT) begin
                acc        <= '0;
                v1         <= 1'b0;
                SAMPLE_NUM <= '0;
                PHASE_OUT  <= '0;
                OUT_VALID  <= 1'b0;
                DONE       <= 1'b0;
            end else begin
                if (active) acc <= acc + inc_reg;
                v1        <= active;
                OUT_VALID <= v1;
                if (v1) PHASE_OUT <= phase_next;

                if (active) begin
                    if (SAMPLE_NUM == LAST_IDX) DONE <= 1'b1;
                    else                        SAMPLE_NUM <= SAMPLE_NUM + 10'd1;
                end
            end
        end
    end

endmodule
